// File: rtl/msrv32_instr_fetch.sv
// ---------------------------------------------------------------------------
// msrv32_instr_fetch
//
// Instruction fetch stage for a 32-bit RISC-V pipeline. It keeps at most one
// request outstanding to instruction memory and presents fetched words to the
// decoder through registered outputs.
//
// Stall handling:
//   A one-entry skid buffer catches a word that arrives while the decoder is
//   stalled.
//
// Redirect handling:
//   Branch redirects take priority over everything else. When a redirect
//   arrives while a request is still in flight, that request is drained and
//   its data is discarded before the new target is fetched.
//
// Ports
//   ms_riscv32_mp_clk_in  : sole clock, rising edge
//   ms_riscv32_mp_rst_in  : synchronous active-high reset
//   stall_in              : decoder cannot take a new instruction
//   branch_taken_in       : redirect request (sampled every cycle)
//   branch_target_in      : redirect address
//   imem_req_out          : instruction memory request
//   imem_addr_out         : request address
//   imem_ack_in           : memory response valid (only while request is high)
//   imem_rdata_in         : returned instruction word
//   instr_out / pc_out    : instruction and its address for the decoder
//   flush_out             : instr_out is not a valid instruction
// ---------------------------------------------------------------------------
module msrv32_instr_fetch #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   BOOT_ADDR = '0
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic             stall_in,
  input  logic             branch_taken_in,
  input  logic [WIDTH-1:0] branch_target_in,
  output logic             imem_req_out,
  output logic [WIDTH-1:0] imem_addr_out,
  input  logic             imem_ack_in,
  input  logic [WIDTH-1:0] imem_rdata_in,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] pc_out,
  output logic             flush_out
);

  // addi x0, x0, 0
  localparam logic [WIDTH-1:0] NOP  = WIDTH'(32'h0000_0013);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(4);

  // FETCH : request outstanding at fetch_pc
  // HOLD  : skid buffer full, waiting for the decoder, no request
  // DRAIN : stale request in flight; its data is dropped, then fetch target_q
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] fetch_pc,   fetch_pc_next;
  logic [WIDTH-1:0] target_q,   target_next;
  logic [WIDTH-1:0] instr_q,    instr_next;
  logic [WIDTH-1:0] pc_q,       pc_next;
  logic [WIDTH-1:0] skid_instr, skid_instr_next;
  logic [WIDTH-1:0] skid_pc,    skid_pc_next;
  logic             valid_q,    valid_next;

  // An ack only means something while a request is actually being driven.
  logic ack;
  assign ack = imem_ack_in & imem_req_out;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (branch_taken_in) begin
          // Without an ack the old request is still in flight and must drain.
          state_next = ack ? FETCH : DRAIN;
        end else if (ack && stall_in && valid_q) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (branch_taken_in || !stall_in) begin
          state_next = FETCH;
        end
      end
      DRAIN: begin
        if (ack) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: the request is dropped only while the skid is full; in
  // DRAIN the stale address stays on the bus until memory acknowledges it.
  // -------------------------------------------------------------------------
  always_comb begin
    imem_req_out  = (state != HOLD);
    imem_addr_out = fetch_pc;
  end

  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign flush_out = ~valid_q;

  // -------------------------------------------------------------------------
  // Datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    fetch_pc_next   = fetch_pc;
    target_next     = target_q;
    instr_next      = instr_q;
    pc_next         = pc_q;
    skid_instr_next = skid_instr;
    skid_pc_next    = skid_pc;
    valid_next      = valid_q;

    case (state)
      FETCH: begin
        if (branch_taken_in) begin
          valid_next = 1'b0;
          if (ack) begin
            // Returned word belongs to the wrong path; drop it.
            fetch_pc_next = branch_target_in;
          end else begin
            target_next = branch_target_in;
          end
        end else if (ack) begin
          fetch_pc_next = fetch_pc + STEP;
          if (stall_in && valid_q) begin
            // Decoder still holds a valid word: park the new one.
            skid_instr_next = imem_rdata_in;
            skid_pc_next    = fetch_pc;
          end else begin
            instr_next = imem_rdata_in;
            pc_next    = fetch_pc;
            valid_next = 1'b1;
          end
        end else if (!stall_in) begin
          // Decoder consumed the current word and nothing replaced it.
          valid_next = 1'b0;
        end
      end

      HOLD: begin
        if (branch_taken_in) begin
          // No request is in flight, so the target can be fetched at once.
          valid_next    = 1'b0;
          fetch_pc_next = branch_target_in;
        end else if (!stall_in) begin
          instr_next = skid_instr;
          pc_next    = skid_pc;
          valid_next = 1'b1;
        end
      end

      DRAIN: begin
        valid_next = 1'b0;
        if (branch_taken_in) begin
          target_next = branch_target_in;
        end
        if (ack) begin
          fetch_pc_next = branch_taken_in ? branch_target_in : target_q;
        end
      end

      default: begin
        valid_next = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      fetch_pc   <= BOOT_ADDR;
      target_q   <= BOOT_ADDR;
      instr_q    <= NOP;
      pc_q       <= BOOT_ADDR;
      skid_instr <= NOP;
      skid_pc    <= BOOT_ADDR;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc   <= fetch_pc_next;
      target_q   <= target_next;
      instr_q    <= instr_next;
      pc_q       <= pc_next;
      skid_instr <= skid_instr_next;
      skid_pc    <= skid_pc_next;
      valid_q    <= valid_next;
    end
  end

endmodule
